deadtime_gate_driver: RTL and testbench
=======================================

// Module: deadtime_gate_driver
// PURPOSE
//  Converts the single raw DPWM high-side command (C_1) into a complementary, dead-time-protected
//  pair of gate signals for the half-bridge. It sits directly downstream of the DPWM and drives GPIO.
//  The block guarantees that the two gates are never high together.
//  Each edge gets a separately programmable, runtime-settable dead time, counted in clk cycles.
// PARAMETERS
//  DT_W    3  width of the dead-time count inputs (max dead time is 2**DT_W-1 cycles)
//  MIN_ON  2  minimum gate on-time in cycles; used only when DT_MIN_PULSE_EN is defined
// PORTS
//  clk       in   1     system clock
//  resetn    in   1     reset, asynchronous, active-low
//  en        in   1     1 = switching allowed; 0 = force both gates off
//  pwm_in    in   1     raw DPWM command; 1 requests high-side on, 0 requests low-side on
//  dt_rise   in   DT_W  dead time (cycles) before gate_hi turns on
//  dt_fall   in   DT_W  dead time (cycles) before gate_lo turns on
//  gate_hi   out  1     high-side gate drive
//  gate_lo   out  1     low-side gate drive
//  dt_active out  1     1 while in a dead-time interval
// BEHAVIOUR
//  - Reset value of all state: state=OFF, gate_hi=0, gate_lo=0, dt_active=0, pwm_q=0, cnt=0.
//    Reset asserted mid-operation forces both gates low immediately (asynchronous).
//  - pwm_in is registered once into pwm_q, which costs one cycle of input latency.
//    dt_rise and dt_fall are sampled only when a DT state is entered.
//  - Outputs are a Moore decode of the state register:
//    gate_hi=(state==HI), gate_lo=(state==LO), dt_active=(state==DT_LH|DT_HL).
//  - States are OFF, DT_LH, HI, DT_HL, LO. en=0 has priority in every state: next edge goes to OFF.
//    - OFF   : if en=1, go to DT_LH when pwm_q=1, otherwise to DT_HL.
//              Switching always starts with a dead time.
//    - DT_LH : if pwm_q=0, go to DT_HL and reload the counter with dt_fall.
//              Else if cnt==0, go to HI. Else decrement cnt.
//    - HI    : if pwm_q=0, go to DT_HL.
//    - DT_HL : if pwm_q=1, go to DT_LH and reload the counter with dt_rise.
//              Else if cnt==0, go to LO. Else decrement cnt.
//    - LO    : if pwm_q=1, go to DT_LH.
//  - Counter load on entry to a DT state is cnt = max(dt,1)-1.
//    Each dead time therefore lasts max(dt,1) cycles, and dt=0 is treated as 1.
//    A zero dead time is impossible.
//  - Latency: pwm_in sampled low at edge t → gate_hi falls at t+1 → gate_lo rises at t+1+max(dt_fall,1).
//    The rising direction is symmetric and uses dt_rise.
//  - Invariant: gate_hi & gate_lo is never 1.
//    Every HI↔LO change passes through a DT state of at least 1 cycle.
// CONFIGURATION
//  DT_MIN_PULSE_EN defined:
//    - A MIN_ON-cycle on-timer loads on entry to HI or LO.
//    - A pwm_q change is ignored (deferred) until the timer expires. The transition is then taken
//      only if pwm_q still requests it, so pulses shorter than MIN_ON are swallowed.
//    - en=0 and reset override the timer.
//  DT_MIN_PULSE_EN undefined:
//    - No timer logic; HI/LO leave on the first edge at which pwm_q differs.
// TESTING
//  1. Reset: resetn=0 with pwm_in=1, en=1 → gate_hi=gate_lo=dt_active=0 at once.
//     Release with en=0 → outputs stay 0.
//  2. pwm_in=1 held, dt_rise=3, en rises sampled at edge e → dt_active=1 for e..e+2; gate_hi=1 from e+3.
//  3. In HI, dt_fall=2, pwm_in sampled 0 at edge t → gate_hi=0 at t+1, gate_lo=1 at t+3.
//     Repeat with dt_fall=0 → gate_lo=1 at t+2.
//  4. In DT_LH with dt_rise=5, pwm_in low for 1 cycle → DT_HL reload; gates stay low until LO entered.
//     Bench asserts !(gate_hi&gate_lo) every cycle across random pwm_in/dt streams.
//  5. In HI, en→0 at edge t → both gates 0 at t. en→1 with pwm_in=1 → DT_LH dead time again before HI.
//  6. DT_MIN_PULSE_EN, MIN_ON=4: 1-cycle pwm_in high pulse 1 cycle after entering LO → gate_lo stays 1,
//     no DT_LH entered. Without the macro → DT_LH is entered, then DT_HL.

Source files
------------

// File: rtl/deadtime_gate_driver.sv
// Complementary half-bridge gate driver with per-edge programmable dead time.
// Optional minimum on-time filter is enabled by defining DT_MIN_PULSE_EN.
module deadtime_gate_driver #(
   parameter int DT_W   = 3,
   parameter int MIN_ON = 2
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            en,
   input  logic            pwm_in,
   input  logic [DT_W-1:0] dt_rise,
   input  logic [DT_W-1:0] dt_fall,
   output logic            gate_hi,
   output logic            gate_lo,
   output logic            dt_active
);

   typedef enum logic [2:0] {
      OFF   = 3'd0,
      DT_LH = 3'd1,
      HI    = 3'd2,
      DT_HL = 3'd3,
      LO    = 3'd4
   } state_t;

   if (MIN_ON < 1) begin : g_bad_min_on
      $error("MIN_ON must be at least 1");
   end

   state_t          state, state_nxt;
   logic            pwm_q;
   logic [DT_W-1:0] cnt, cnt_nxt;
   logic            hold;

   // dt=0 behaves as dt=1 so a dead time can never collapse to zero cycles.
   function automatic logic [DT_W-1:0] dt_load(input logic [DT_W-1:0] dt);
      return (dt == '0) ? '0 : dt - DT_W'(1);
   endfunction

`ifdef DT_MIN_PULSE_EN
   localparam int TW = (MIN_ON > 1) ? $clog2(MIN_ON) : 1;

   logic [TW-1:0] tmr, tmr_nxt;

   assign hold = (tmr != '0);

   always_comb begin
      tmr_nxt = '0;
      if (state_nxt == HI || state_nxt == LO) begin
         if (state_nxt != state)
            tmr_nxt = TW'(MIN_ON - 1);
         else if (tmr != '0)
            tmr_nxt = tmr - TW'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         tmr <= '0;
      else
         tmr <= tmr_nxt;
   end
`else
   assign hold = 1'b0;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= OFF;
         pwm_q <= 1'b0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         pwm_q <= pwm_in;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (!en) begin
         state_nxt = OFF;
      end else begin
         case (state)
            OFF: begin
               if (pwm_q) begin
                  state_nxt = DT_LH;
                  cnt_nxt   = dt_load(dt_rise);
               end else begin
                  state_nxt = DT_HL;
                  cnt_nxt   = dt_load(dt_fall);
               end
            end
            DT_LH: begin
               if (!pwm_q) begin
                  state_nxt = DT_HL;
                  cnt_nxt   = dt_load(dt_fall);
               end else if (cnt == '0) begin
                  state_nxt = HI;
               end else begin
                  cnt_nxt = cnt - DT_W'(1);
               end
            end
            HI: begin
               if (!pwm_q && !hold) begin
                  state_nxt = DT_HL;
                  cnt_nxt   = dt_load(dt_fall);
               end
            end
            DT_HL: begin
               if (pwm_q) begin
                  state_nxt = DT_LH;
                  cnt_nxt   = dt_load(dt_rise);
               end else if (cnt == '0) begin
                  state_nxt = LO;
               end else begin
                  cnt_nxt = cnt - DT_W'(1);
               end
            end
            LO: begin
               if (pwm_q && !hold) begin
                  state_nxt = DT_LH;
                  cnt_nxt   = dt_load(dt_rise);
               end
            end
            default: state_nxt = OFF;
         endcase
      end
   end

   // Outputs decode straight from the state register so reset clears them asynchronously.
   assign gate_hi   = (state == HI);
   assign gate_lo   = (state == LO);
   assign dt_active = (state == DT_LH) || (state == DT_HL);

endmodule

// File: tb/tb_deadtime_gate_driver.sv
// Randomized self-checking bench for deadtime_gate_driver against a behavioural model
// that tracks which gate is on and how many dead-time cycles remain.
module tb_deadtime_gate_driver;

   localparam int DT_W   = 3;
   localparam int MIN_ON = 4;

   logic            clk = 1'b0;
   logic            resetn;
   logic            en;
   logic            pwm_in;
   logic [DT_W-1:0] dt_rise;
   logic [DT_W-1:0] dt_fall;
   logic            gate_hi;
   logic            gate_lo;
   logic            dt_active;

   int n_checks = 0;
   int n_errors = 0;

   // Model: m_on/m_side say which gate conducts, m_dead counts remaining dead cycles.
   bit m_pq, m_off, m_dir, m_on, m_side;
   int m_dead, m_age;

   deadtime_gate_driver #(.DT_W(DT_W), .MIN_ON(MIN_ON)) dut (
      .clk(clk), .resetn(resetn), .en(en), .pwm_in(pwm_in),
      .dt_rise(dt_rise), .dt_fall(dt_fall),
      .gate_hi(gate_hi), .gate_lo(gate_lo), .dt_active(dt_active)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int dead_len(input int d);
      return (d < 1) ? 1 : d;
   endfunction

   task automatic model_reset();
      m_pq = 0; m_off = 1; m_dead = 0; m_on = 0; m_age = 0; m_dir = 0; m_side = 0;
   endtask

   task automatic model_edge();
      bit pq, ok;
      pq   = m_pq;
      m_pq = pwm_in;
      if (!en) begin
         m_off = 1; m_dead = 0; m_on = 0;
      end else if (m_off) begin
         m_off  = 0;
         m_dir  = pq;
         m_dead = dead_len(pq ? int'(dt_rise) : int'(dt_fall));
      end else if (m_dead > 0) begin
         if (pq != m_dir) begin
            m_dir  = pq;
            m_dead = dead_len(pq ? int'(dt_rise) : int'(dt_fall));
         end else begin
            m_dead--;
            if (m_dead == 0) begin
               m_on = 1; m_side = m_dir; m_age = 0;
            end
         end
      end else if (m_on) begin
`ifdef DT_MIN_PULSE_EN
         ok = (m_age >= MIN_ON - 1);
`else
         ok = 1;
`endif
         if (pq != m_side && ok) begin
            m_on   = 0;
            m_dir  = pq;
            m_dead = dead_len(pq ? int'(dt_rise) : int'(dt_fall));
         end else begin
            m_age++;
         end
      end
   endtask

   task automatic compare_all(input string ph);
      check_eq({ph, "_gate_hi"}, int'(gate_hi), int'(m_on && m_side));
      check_eq({ph, "_gate_lo"}, int'(gate_lo), int'(m_on && !m_side));
      check_eq({ph, "_dt_active"}, int'(dt_active), int'(m_dead > 0));
      check_eq({ph, "_overlap"}, int'(gate_hi & gate_lo), 0);
   endtask

   task automatic step(input string ph);
      @(posedge clk);
      model_edge();
      #1;
      compare_all(ph);
   endtask

   initial begin
      bit seen_dt, seen_hi;

      // Async reset while asking to switch.
      resetn = 1'b1; en = 1'b1; pwm_in = 1'b1; dt_rise = '0; dt_fall = '0;
      #2 resetn = 1'b0;
      model_reset();
      #1 compare_all("rst_async");
      repeat (2) @(negedge clk);
      en = 1'b0;
      #2 resetn = 1'b1;
      repeat (3) step("rst_release");

      // Rising dead time of 3 cycles.
      dt_rise = 3'd3; dt_fall = 3'd1; pwm_in = 1'b1;
      step("t2_pre");
      en = 1'b1;
      step("t2_e0");
      check_eq("t2_dt_e0", int'(dt_active), 1);
      step("t2_e1");
      check_eq("t2_dt_e1", int'(dt_active), 1);
      step("t2_e2");
      check_eq("t2_dt_e2", int'(dt_active), 1);
      step("t2_e3");
      check_eq("t2_hi_e3", int'(gate_hi), 1);

      // Falling dead time 2, then 0.
      dt_fall = 3'd2; pwm_in = 1'b0;
      step("t3_t0");
      check_eq("t3_hi_t0", int'(gate_hi), 1);
      step("t3_t1");
      check_eq("t3_hi_t1", int'(gate_hi), 0);
      step("t3_t2");
      check_eq("t3_lo_t2", int'(gate_lo), 0);
      step("t3_t3");
      check_eq("t3_lo_t3", int'(gate_lo), 1);
      dt_rise = 3'd1; pwm_in = 1'b1;
      for (int i = 0; i < 20 && !gate_hi; i++) step("t3_wait");
      check_eq("t3_reach_hi", int'(gate_hi), 1);
      repeat (MIN_ON) step("t3_dwell");
      dt_fall = 3'd0; pwm_in = 1'b0;
      step("t3b_t0");
      step("t3b_t1");
      check_eq("t3b_lo_t1", int'(gate_lo), 0);
      step("t3b_t2");
      check_eq("t3b_lo_t2", int'(gate_lo), 1);

      // Glitch inside rising dead time forces a reload toward LO.
      repeat (MIN_ON) step("t4_dwell");
      dt_rise = 3'd5; dt_fall = 3'd2; pwm_in = 1'b1;
      step("t4_glitch");
      pwm_in = 1'b0;
      seen_hi = 0;
      for (int i = 0; i < 10; i++) begin
         step("t4_run");
         if (gate_hi) seen_hi = 1;
      end
      check_eq("t4_no_hi", int'(seen_hi), 0);
      check_eq("t4_lo_end", int'(gate_lo), 1);

      // en drop from HI, then restart through dead time.
      dt_rise = 3'd2; pwm_in = 1'b1;
      for (int i = 0; i < 20 && !gate_hi; i++) step("t5_wait");
      check_eq("t5_reach_hi", int'(gate_hi), 1);
      en = 1'b0;
      step("t5_off");
      check_eq("t5_off_hi", int'(gate_hi), 0);
      check_eq("t5_off_lo", int'(gate_lo), 0);
      en = 1'b1;
      step("t5_on");
      check_eq("t5_restart_dt", int'(dt_active), 1);
      check_eq("t5_restart_hi", int'(gate_hi), 0);

      // Short pulse right after entering LO.
      dt_fall = 3'd1; dt_rise = 3'd1; pwm_in = 1'b0;
      for (int i = 0; i < 20 && !gate_lo; i++) step("t6_wait");
      check_eq("t6_reach_lo", int'(gate_lo), 1);
      step("t6_idle");
      pwm_in = 1'b1;
      step("t6_pulse");
      pwm_in = 1'b0;
      seen_dt = 0;
      for (int i = 0; i < 8; i++) begin
         step("t6_run");
         if (dt_active) seen_dt = 1;
      end
`ifdef DT_MIN_PULSE_EN
      check_eq("t6_dt_seen", int'(seen_dt), 0);
`else
      check_eq("t6_dt_seen", int'(seen_dt), 1);
`endif

      // Random streams with an async reset in the middle.
      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) begin
            resetn = 1'b0;
            model_reset();
            #1 compare_all("rand_rst");
            #1 resetn = 1'b1;
         end
         en = ($urandom_range(0, 49) != 0);
         if ($urandom_range(0, 3) == 0) pwm_in = ~pwm_in;
         if ($urandom_range(0, 7) == 0) dt_rise = DT_W'($urandom_range(0, 7));
         if ($urandom_range(0, 7) == 0) dt_fall = DT_W'($urandom_range(0, 7));
         step("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
